// File: rtl/trail_engine_if.sv
// trail_engine_if -- playfield RAM bus between the trail engine and the RAM.
//   ram_addr  : {x,y} cell address (engine -> RAM)
//   ram_wdata : 3-bit colour to write (engine -> RAM)
//   ram_wren  : write enable (engine -> RAM)
//   ram_q     : read data, valid the cycle after ram_addr (RAM -> engine)
// Modports: master (engine side), slave (RAM side).
interface trail_engine_if #(
   parameter int X_BITS = 8,
   parameter int Y_BITS = 7
);
   logic [X_BITS+Y_BITS-1:0] ram_addr;
   logic [2:0]               ram_wdata;
   logic                     ram_wren;
   logic [2:0]               ram_q;

   modport master (output ram_addr, ram_wdata, ram_wren, input ram_q);
   modport slave  (input ram_addr, ram_wdata, ram_wren, output ram_q);
endinterface

// File: rtl/trail_engine.sv
// trail_engine -- light-cycle style trail game step engine.
// On each tick every alive player advances one cell, the target cells are
// read back from the playfield RAM, collisions/trail hits/field exits kill
// players, the trail colour (or 7 for a crash) is written, and the game
// state is updated.
// Ports:
//   CLOCK_50  : clock, all state changes on the rising edge
//   reset     : synchronous, active-high reset
//   tick      : one-cycle game-step strobe
//   dir_in    : requested direction per player (00 up,01 down,10 left,11 right)
//   dir_we    : per-player latch strobe for dir_in
//   ram       : playfield RAM bus (trail_engine_if.master)
//   pos       : {x,y} per player, P0 in the LSBs
//   alive     : per-player alive flags
//   busy      : high while a step is in progress
//   game_over : high when at most one player is alive
//   winner    : index of the sole survivor, 7 if none
// Build option: define TRAIL_WRAP_EN to make players wrap around the field
// edges instead of dying when they leave it.
module trail_engine #(
   parameter int NUM_PLAYERS = 4,
   parameter int X_BITS      = 8,
   parameter int Y_BITS      = 7,
   parameter int X_MAX       = 160,
   parameter int Y_MAX       = 120,
   parameter logic [NUM_PLAYERS*(X_BITS+Y_BITS)-1:0] START_POS =
      {8'd0, 7'd119, 8'd158, 7'd1, 8'd0, 7'd1, 8'd158, 7'd119},
   parameter logic [2*NUM_PLAYERS-1:0] START_DIR = 8'b11_10_01_00
) (
   input  logic                                  CLOCK_50,
   input  logic                                  reset,
   input  logic                                  tick,
   input  logic [2*NUM_PLAYERS-1:0]              dir_in,
   input  logic [NUM_PLAYERS-1:0]                dir_we,
   trail_engine_if.master                        ram,
   output logic [NUM_PLAYERS*(X_BITS+Y_BITS)-1:0] pos,
   output logic [NUM_PLAYERS-1:0]                alive,
   output logic                                  busy,
   output logic                                  game_over,
   output logic [2:0]                            winner
);

   localparam int PW = X_BITS + Y_BITS;
   localparam int CW = $clog2(NUM_PLAYERS + 1);

   // Coordinates are stepped one bit wider so underflow shows in the MSB
   // and overflow is a plain compare against the field size.
   localparam logic [X_BITS:0] X_LIM = (X_BITS+1)'(X_MAX);
   localparam logic [Y_BITS:0] Y_LIM = (Y_BITS+1)'(Y_MAX);
   localparam logic [X_BITS:0] X_ONE = (X_BITS+1)'(1);
   localparam logic [Y_BITS:0] Y_ONE = (Y_BITS+1)'(1);
`ifdef TRAIL_WRAP_EN
   localparam logic [X_BITS-1:0] X_LAST = X_BITS'(X_MAX - 1);
   localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(Y_MAX - 1);
`endif

   typedef enum logic [2:0] {IDLE, MOVE, READ, CHECK, WRITE, DONE} state_t;

   typedef struct packed {
      logic              oob;
      logic [X_BITS-1:0] x;
      logic [Y_BITS-1:0] y;
   } cell_t;

   state_t                               state_q, state_d;
   logic [CW-1:0]                        cnt_q, cnt_d;
   logic [NUM_PLAYERS-1:0][X_BITS-1:0]   x_q, nx_q;
   logic [NUM_PLAYERS-1:0][Y_BITS-1:0]   y_q, ny_q;
   logic [NUM_PLAYERS-1:0][1:0]          dir_q;
   logic [NUM_PLAYERS-1:0][2:0]          col_q;
   logic [NUM_PLAYERS-1:0]               alive_q, oob_q, kill_q, kill_d, alive_nx;
   logic                                 go_q, go_d;
   logic [2:0]                           win_q, win_d;
   logic [3:0]                           n_alive;
   cell_t [NUM_PLAYERS-1:0]              mv;
   logic [PW-1:0]                        addr_c;
   logic [2:0]                           wdata_c;
   logic                                 wren_c;

   // Next cell of one player from its stored direction.
   function automatic cell_t step_cell(input logic [X_BITS-1:0] x,
                                       input logic [Y_BITS-1:0] y,
                                       input logic [1:0]        d);
      logic [X_BITS:0] xe;
      logic [Y_BITS:0] ye;
      logic            und, ovf;
      cell_t           c;
      xe  = {1'b0, x};
      ye  = {1'b0, y};
      und = 1'b0;
      ovf = 1'b0;
      case (d)
         2'b00:   begin ye = ye - Y_ONE; und = ye[Y_BITS];    end
         2'b01:   begin ye = ye + Y_ONE; ovf = (ye >= Y_LIM); end
         2'b10:   begin xe = xe - X_ONE; und = xe[X_BITS];    end
         default: begin xe = xe + X_ONE; ovf = (xe >= X_LIM); end
      endcase
      c.x   = xe[X_BITS-1:0];
      c.y   = ye[Y_BITS-1:0];
      c.oob = und | ovf;
`ifdef TRAIL_WRAP_EN
      if (und | ovf) begin
         c.oob = 1'b0;
         case (d)
            2'b00:   c.y = Y_LAST;
            2'b01:   c.y = '0;
            2'b10:   c.x = X_LAST;
            default: c.x = '0;
         endcase
      end
`endif
      return c;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_PLAYERS; i++)
         mv[i] = step_cell(x_q[i], y_q[i], dir_q[i]);
   end

   // Deaths of this step: trail hit, field exit, or two alive players
   // heading for the same cell (every player sharing that cell dies).
   always_comb begin
      kill_d = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         kill_d[i] = alive_q[i] & (oob_q[i] | (col_q[i] != 3'd0));
         for (int j = 0; j < NUM_PLAYERS; j++)
            if (j != i && alive_q[i] && alive_q[j] && !oob_q[i] && !oob_q[j] &&
                nx_q[i] == nx_q[j] && ny_q[i] == ny_q[j])
               kill_d[i] = 1'b1;
      end
   end

   // Survivor count and winner for the end of the step.
   always_comb begin
      alive_nx = alive_q & ~kill_q;
      n_alive  = '0;
      win_d    = 3'd7;
      for (int i = 0; i < NUM_PLAYERS; i++)
         if (alive_nx[i]) begin
            n_alive = n_alive + 4'd1;
            win_d   = 3'(i);
         end
      go_d = (n_alive <= 4'd1);
      if (n_alive != 4'd1) win_d = 3'd7;
   end

   // FSM state register.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state and RAM bus.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_c  = '0;
      wdata_c = '0;
      wren_c  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (tick && !go_q) state_d = MOVE;
         end
         MOVE: begin
            cnt_d   = '0;
            state_d = READ;
         end
         READ: begin
            // Address player cnt; the data for player cnt-1 arrives now.
            for (int i = 0; i < NUM_PLAYERS; i++)
               if (cnt_q == CW'(i) && alive_q[i]) addr_c = {nx_q[i], ny_q[i]};
            if (cnt_q == CW'(NUM_PLAYERS)) begin
               cnt_d   = '0;
               state_d = CHECK;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         CHECK: begin
            cnt_d   = '0;
            state_d = WRITE;
         end
         WRITE: begin
            // Players dead before this step, or just gone off the field,
            // leave the RAM untouched.
            for (int i = 0; i < NUM_PLAYERS; i++)
               if (cnt_q == CW'(i) && alive_q[i] && !oob_q[i]) begin
                  wren_c  = 1'b1;
                  addr_c  = {nx_q[i], ny_q[i]};
                  wdata_c = kill_q[i] ? 3'd7 : 3'(i + 1);
               end
            if (cnt_q == CW'(NUM_PLAYERS - 1)) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Reset gates the bus immediately so an aborted write never lands.
   assign ram.ram_addr  = reset ? '0 : addr_c;
   assign ram.ram_wdata = reset ? '0 : wdata_c;
   assign ram.ram_wren  = reset ? 1'b0 : wren_c;

   // Player datapath.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            x_q[i]   <= START_POS[i*PW+Y_BITS +: X_BITS];
            y_q[i]   <= START_POS[i*PW +: Y_BITS];
            dir_q[i] <= START_DIR[2*i +: 2];
         end
         nx_q    <= '0;
         ny_q    <= '0;
         col_q   <= '0;
         oob_q   <= '0;
         kill_q  <= '0;
         alive_q <= '1;
         go_q    <= 1'b0;
         win_q   <= 3'd7;
      end else begin
         // A U-turn request (same axis, opposite sense) is dropped.
         for (int i = 0; i < NUM_PLAYERS; i++)
            if (dir_we[i] && !(dir_in[2*i+1] == dir_q[i][1] && dir_in[2*i] != dir_q[i][0]))
               dir_q[i] <= dir_in[2*i +: 2];
         case (state_q)
            MOVE: begin
               for (int i = 0; i < NUM_PLAYERS; i++) begin
                  nx_q[i]  <= alive_q[i] ? mv[i].x : x_q[i];
                  ny_q[i]  <= alive_q[i] ? mv[i].y : y_q[i];
                  oob_q[i] <= alive_q[i] & mv[i].oob;
               end
            end
            READ: begin
               for (int i = 0; i < NUM_PLAYERS; i++)
                  if (cnt_q == CW'(i + 1)) col_q[i] <= ram.ram_q;
            end
            CHECK: kill_q <= kill_d;
            DONE: begin
               // Crashed players stop on their crash cell; a player that
               // left the field keeps its last valid cell.
               for (int i = 0; i < NUM_PLAYERS; i++)
                  if (alive_q[i] && !oob_q[i]) begin
                     x_q[i] <= nx_q[i];
                     y_q[i] <= ny_q[i];
                  end
               alive_q <= alive_nx;
               go_q    <= go_d;
               win_q   <= win_d;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      pos = '0;
      for (int i = 0; i < NUM_PLAYERS; i++)
         pos[i*PW +: PW] = {x_q[i], y_q[i]};
   end

   assign alive     = alive_q;
   assign busy      = (state_q != IDLE);
   assign game_over = go_q;
   assign winner    = win_q;

endmodule

// File: tb/tb_trail_engine.sv
// tb_trail_engine -- self-checking bench for trail_engine with a behavioural
// playfield RAM, a step-level game model and a write scoreboard.
module tb_trail_engine;
   localparam int NP = 4;
   localparam int XB = 8;
   localparam int YB = 7;
   localparam logic [59:0] SP = {8'd2, 7'd60, 8'd13, 7'd5, 8'd9, 7'd5, 8'd158, 7'd119};
   localparam logic [7:0]  SD = 8'b10_10_11_00;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic [7:0]  dir_in = '0;
   logic [3:0]  dir_we = '0;
   logic [59:0] pos;
   logic [3:0]  alive;
   logic        busy, game_over;
   logic [2:0]  winner;

   always #5 clk = ~clk;

   trail_engine_if #(.X_BITS(XB), .Y_BITS(YB)) ram_if ();

   trail_engine #(.NUM_PLAYERS(NP), .X_BITS(XB), .Y_BITS(YB), .X_MAX(160), .Y_MAX(120),
                  .START_POS(SP), .START_DIR(SD)) dut (
      .CLOCK_50(clk), .reset(rst), .tick(tick), .dir_in(dir_in), .dir_we(dir_we),
      .ram(ram_if), .pos(pos), .alive(alive), .busy(busy), .game_over(game_over),
      .winner(winner));

   // Playfield RAM with one-cycle read latency plus a bench poke/clear port.
   logic [2:0]  mem [0:32767];
   logic        clr = 1'b0, poke = 1'b0;
   logic [14:0] poke_a = '0;
   logic [2:0]  poke_d = '0;
   always @(posedge clk) begin
      if (clr) for (int k = 0; k < 32768; k++) mem[k] <= 3'd0;
      else if (poke) mem[poke_a] <= poke_d;
      else if (ram_if.ram_wren) mem[ram_if.ram_addr] <= ram_if.ram_wdata;
      ram_if.ram_q <= mem[ram_if.ram_addr];
   end

   int          checks = 0, errors = 0;
   logic [17:0] exp_q[$];
   logic [17:0] sb_e;
   int          mx[NP], my[NP];
   logic [1:0]  mdir[NP];
   logic [3:0]  malive;
   logic        mgo;
   logic [2:0]  mwin;
   int          lat;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic model_reset();
      mx = '{158, 9, 13, 2};
      my = '{119, 5, 5, 60};
      mdir = '{2'd0, 2'd3, 2'd2, 2'd2};
      malive = 4'hF; mgo = 1'b0; mwin = 3'd7;
      exp_q.delete();
   endtask

   task automatic model_dir(input int p, input logic [1:0] d);
      if ((d ^ mdir[p]) != 2'b01) mdir[p] = d;
   endtask

   // One game step: predicted RAM writes go to exp_q in player order.
   task automatic model_step();
      int nx[NP], ny[NP];
      bit oob[NP], kill[NP];
      int n;
      for (int i = 0; i < NP; i++) begin
         nx[i] = mx[i]; ny[i] = my[i]; oob[i] = 0; kill[i] = 0;
         if (malive[i]) begin
            case (mdir[i])
               2'd0: ny[i] = ny[i] - 1;
               2'd1: ny[i] = ny[i] + 1;
               2'd2: nx[i] = nx[i] - 1;
               default: nx[i] = nx[i] + 1;
            endcase
            if (nx[i] < 0 || nx[i] >= 160 || ny[i] < 0 || ny[i] >= 120) begin
`ifdef TRAIL_WRAP_EN
               nx[i] = (nx[i] + 160) % 160;
               ny[i] = (ny[i] + 120) % 120;
`else
               oob[i] = 1; kill[i] = 1;
`endif
            end
            if (!oob[i] && mem[{8'(nx[i]), 7'(ny[i])}] != 3'd0) kill[i] = 1;
         end
      end
      for (int i = 0; i < NP; i++)
         for (int j = i + 1; j < NP; j++)
            if (malive[i] && malive[j] && !oob[i] && !oob[j] && nx[i] == nx[j] && ny[i] == ny[j]) begin
               kill[i] = 1; kill[j] = 1;
            end
      for (int i = 0; i < NP; i++)
         if (malive[i] && !oob[i]) begin
            exp_q.push_back({8'(nx[i]), 7'(ny[i]), (kill[i] ? 3'd7 : 3'(i + 1))});
            mx[i] = nx[i]; my[i] = ny[i];
         end
      for (int i = 0; i < NP; i++) if (kill[i]) malive[i] = 1'b0;
      n = 0; mwin = 3'd7;
      for (int i = 0; i < NP; i++) if (malive[i]) begin n++; mwin = 3'(i); end
      mgo = (n <= 1);
      if (n != 1) mwin = 3'd7;
   endtask

   function automatic logic [59:0] model_pos();
      logic [59:0] r;
      for (int i = 0; i < NP; i++) r[i*15 +: 15] = {8'(mx[i]), 7'(my[i])};
      return r;
   endfunction

   task automatic do_reset();
      @(negedge clk); rst = 1'b1; clr = 1'b1; tick = 1'b0; dir_we = '0; poke = 1'b0;
      @(negedge clk); clr = 1'b0;
      @(negedge clk); rst = 1'b0;
      model_reset();
   endtask

   task automatic do_poke(input logic [7:0] x, input logic [6:0] y, input logic [2:0] d);
      @(negedge clk); poke = 1'b1; poke_a = {x, y}; poke_d = d;
      @(negedge clk); poke = 1'b0;
   endtask

   // Pulse tick, then follow the step, scoring each RAM write as it appears.
   task automatic do_tick(output int n);
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         if (ram_if.ram_wren === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL ram_write: unexpected write addr=%h data=%0d", ram_if.ram_addr, ram_if.ram_wdata);
            end else begin
               sb_e = exp_q.pop_front();
               if ({ram_if.ram_addr, ram_if.ram_wdata} !== sb_e) begin
                  errors++;
                  $display("FAIL ram_write: got addr=%h data=%0d, expected addr=%h data=%0d",
                           ram_if.ram_addr, ram_if.ram_wdata, sb_e[17:3], sb_e[2:0]);
               end
            end
         end
         n++;
         @(negedge clk);
      end
      if (n >= 100) begin
         checks++; errors++;
         $display("FAIL step_timeout: busy still high after %0d cycles", n);
      end
   endtask

   task automatic test_reset();
      @(negedge clk); rst = 1'b1; clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      model_reset();
      checks++; if (pos !== SP) begin errors++; $display("FAIL reset_pos: got %h, expected %h", pos, SP); end
      checks++; if (alive !== 4'hF) begin errors++; $display("FAIL reset_alive: got %b, expected 1111", alive); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b, expected 0", game_over); end
      checks++; if (winner !== 3'd7) begin errors++; $display("FAIL reset_winner: got %0d, expected 7", winner); end
      checks++; if (ram_if.ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b, expected 0", ram_if.ram_wren); end
      checks++; if (ram_if.ram_addr !== 15'd0) begin errors++; $display("FAIL reset_addr: got %h, expected 0", ram_if.ram_addr); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_first_step();
      model_step();
      do_tick(lat);
      checks++; if (lat !== 12) begin errors++; $display("FAIL first_latency: got %0d cycles, expected 12", lat); end
      checks++; if (pos[14:0] !== {8'd158, 7'd118}) begin errors++; $display("FAIL first_p0_pos: got %h, expected %h", pos[14:0], {8'd158, 7'd118}); end
      checks++; if (alive !== 4'b1111) begin errors++; $display("FAIL first_alive: got %b, expected 1111", alive); end
      checks++; if (pos !== model_pos()) begin errors++; $display("FAIL first_pos: got %h, expected %h", pos, model_pos()); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL first_writes: %0d expected writes missing", exp_q.size()); end
   endtask

   task automatic test_reverse_and_collision();
      @(negedge clk); dir_in = 8'b00_00_00_01; dir_we = 4'b0001;
      @(negedge clk); dir_we = '0;
      model_dir(0, 2'b01);
      model_step();
      do_tick(lat);
      checks++; if (pos[6:0] !== 7'd117) begin errors++; $display("FAIL reverse_p0_y: got %0d, expected 117", pos[6:0]); end
      checks++; if (alive[2:1] !== 2'b00) begin errors++; $display("FAIL collide_alive: got %b, expected 00", alive[2:1]); end
      checks++; if (alive !== malive) begin errors++; $display("FAIL collide_alive_all: got %b, expected %b", alive, malive); end
      checks++; if (pos !== model_pos()) begin errors++; $display("FAIL collide_pos: got %h, expected %h", pos, model_pos()); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL collide_game_over: got %b, expected 0", game_over); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL collide_writes: %0d expected writes missing", exp_q.size()); end
   endtask

   task automatic test_edge_exit();
      do_poke(8'd158, 7'd116, 3'd2);
      model_step();
      do_tick(lat);
      checks++; if (alive[0] !== 1'b0) begin errors++; $display("FAIL exit_p0_alive: got %b, expected 0", alive[0]); end
`ifdef TRAIL_WRAP_EN
      checks++; if (pos[59:45] !== {8'd159, 7'd60}) begin errors++; $display("FAIL exit_p3_pos: got %h, expected %h", pos[59:45], {8'd159, 7'd60}); end
      checks++; if (winner !== 3'd3) begin errors++; $display("FAIL exit_winner: got %0d, expected 3", winner); end
`else
      checks++; if (pos[59:45] !== {8'd0, 7'd60}) begin errors++; $display("FAIL exit_p3_pos: got %h, expected %h", pos[59:45], {8'd0, 7'd60}); end
      checks++; if (winner !== 3'd7) begin errors++; $display("FAIL exit_winner: got %0d, expected 7", winner); end
`endif
      checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL exit_game_over: got %b, expected 1", game_over); end
      checks++; if (alive !== malive || winner !== mwin) begin errors++; $display("FAIL exit_model: alive %b winner %0d, expected %b %0d", alive, winner, malive, mwin); end
      checks++; if (pos !== model_pos()) begin errors++; $display("FAIL exit_pos: got %h, expected %h", pos, model_pos()); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL exit_writes: %0d expected writes missing", exp_q.size()); end
      do_tick(lat);
      checks++; if (lat !== 0) begin errors++; $display("FAIL over_tick_busy: busy for %0d cycles, expected 0", lat); end
   endtask

   task automatic test_color_kill();
      do_reset();
      do_poke(8'd158, 7'd118, 3'd2);
      model_step();
      do_tick(lat);
      checks++; if (alive !== 4'b1110) begin errors++; $display("FAIL color_alive: got %b, expected 1110", alive); end
      checks++; if (pos !== model_pos()) begin errors++; $display("FAIL color_pos: got %h, expected %h", pos, model_pos()); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL color_writes: %0d expected writes missing", exp_q.size()); end
      model_step();
      do_tick(lat);
      checks++; if (pos[14:0] !== {8'd158, 7'd118}) begin errors++; $display("FAIL color_p0_static: got %h, expected %h", pos[14:0], {8'd158, 7'd118}); end
      checks++; if (alive !== 4'b1000) begin errors++; $display("FAIL last_alive: got %b, expected 1000", alive); end
      checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL last_game_over: got %b, expected 1", game_over); end
      checks++; if (winner !== 3'd3) begin errors++; $display("FAIL last_winner: got %0d, expected 3", winner); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL last_writes: %0d expected writes missing", exp_q.size()); end
      for (int t = 0; t < 2; t++) begin
         @(negedge clk); tick = 1'b1;
         for (int c = 0; c < 14; c++) begin
            @(negedge clk); tick = 1'b0;
            checks++;
            if (ram_if.ram_wren !== 1'b0 || busy !== 1'b0) begin
               errors++;
               $display("FAIL over_quiet: wren=%b busy=%b, expected 0 0", ram_if.ram_wren, busy);
            end
         end
      end
   endtask

   task automatic test_reset_mid_write();
      int n;
      do_reset();
      model_step();
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      n = 0;
      while (ram_if.ram_wren !== 1'b1 && n < 50) begin n++; @(negedge clk); end
      checks++; if (n >= 50) begin errors++; $display("FAIL abort_wait: no write seen within %0d cycles", n); end
      #1; rst = 1'b1; exp_q.delete();
      #1;
      checks++; if (ram_if.ram_wren !== 1'b0) begin errors++; $display("FAIL abort_wren_in_reset: got %b, expected 0", ram_if.ram_wren); end
      @(posedge clk); #1;
      checks++; if (ram_if.ram_wren !== 1'b0) begin errors++; $display("FAIL abort_wren_next: got %b, expected 0", ram_if.ram_wren); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, expected 0", busy); end
      repeat (3) @(negedge clk);
      checks++; if (mem[{8'd10, 7'd5}] !== 3'd0) begin errors++; $display("FAIL abort_no_write: cell (10,5)=%0d, expected 0", mem[{8'd10, 7'd5}]); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (pos !== SP || alive !== 4'hF) begin errors++; $display("FAIL abort_state: pos %h alive %b, expected %h 1111", pos, alive, SP); end
      checks++; if (busy !== 1'b0 || ram_if.ram_wren !== 1'b0) begin errors++; $display("FAIL abort_idle: busy %b wren %b, expected 0 0", busy, ram_if.ram_wren); end
   endtask

   initial begin
      test_reset();
      test_first_step();
      test_reverse_and_collision();
      test_edge_exit();
      test_color_kill();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
